rr_bus_arbiter_4: RTL and testbench

Round-robin arbiter and sequencer for the shared 4-to-1 32-bit datapath select. It accepts requests from four requesters, grants one at a time, and drives the 2-bit select and the selected 32-bit payload toward the shared resource. Each grant is held until the resource signals completion, the requester withdraws, or a hold timeout expires. It sits between the requesting units (e.g. PC/ALU/memory-address sources) and the shared operand/address bus.

---
 rtl/rr_bus_arbiter_4.sv | 131 +++++++++++++
 tb/tb_rr_bus_arbiter_4.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rr_bus_arbiter_4.sv
// Round-robin arbiter for four requesters sharing one WIDTH-bit datapath.
// Grants are held until done, withdrawal or hold timeout; the previous winner gets the lowest priority.
module rr_bus_arbiter_4 #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d_in_1,
    input  logic [WIDTH-1:0] d_in_2,
    input  logic [WIDTH-1:0] d_in_3,
    input  logic [WIDTH-1:0] d_in_4,
    input  logic             done,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] d_out,
    output logic             out_valid,
    output logic             timeout
);

    localparam int HOLD_W = $clog2(TIMEOUT) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        grant_d;
    logic [1:0]        sel_d;
    logic [1:0]        last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              valid_d;
    logic              timeout_d;
    logic              tmo_hit;
    logic              release_ev;
    logic [2:0]        win;

    // Returns {found, index}; scanning from the far end lets the nearest hit after ptr win.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign tmo_hit    = (TIMEOUT != 0) && (hold_q == HOLD_LAST);
    assign release_ev = done || !req[sel] || tmo_hit;
    assign win        = pick(req, (state_q == IDLE) ? last_q : sel);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        grant_d   = grant;
        sel_d     = sel;
        last_d    = last_q;
        hold_d    = hold_q;
        valid_d   = out_valid;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win[2]) begin
                    state_d = GRANT;
                    grant_d = 4'b0001 << win[1:0];
                    sel_d   = win[1:0];
                    hold_d  = '0;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                hold_d = hold_q + 1'b1;
                if (release_ev) begin
                    last_d    = sel;
                    hold_d    = '0;
                    // done wins over a coinciding timeout; a withdrawn requester is not "timed out".
                    timeout_d = tmo_hit && !done && req[sel];
                    if (win[2]) begin
                        grant_d = 4'b0001 << win[1:0];
                        sel_d   = win[1:0];
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant     <= 4'b0000;
            sel       <= 2'b00;
            last_q    <= 2'b11;
            hold_q    <= '0;
            out_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant     <= grant_d;
            sel       <= sel_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            out_valid <= valid_d;
            timeout   <= timeout_d;
        end
    end

    always_comb begin
        case (sel)
            2'd0:    d_out = d_in_1;
            2'd1:    d_out = d_in_2;
            2'd2:    d_out = d_in_3;
            default: d_out = d_in_4;
        endcase
    end

endmodule

// File: tb/tb_rr_bus_arbiter_4.sv
// Directed bench for rr_bus_arbiter_4 (TIMEOUT=4): stimulus pushes expected grant cycles,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_rr_bus_arbiter_4;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [3:0]  grant;
        logic [1:0]  sel;
        logic [31:0] data;
        logic        tmo;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic             done;
    logic [WIDTH-1:0] d_in_1, d_in_2, d_in_3, d_in_4;
    logic [3:0]       grant;
    logic [1:0]       sel;
    logic [WIDTH-1:0] d_out;
    logic             out_valid;
    logic             timeout;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    rr_bus_arbiter_4 #(.WIDTH(WIDTH), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d_in_1    (d_in_1),
        .d_in_2    (d_in_2),
        .d_in_3    (d_in_3),
        .d_in_4    (d_in_4),
        .done      (done),
        .grant     (grant),
        .sel       (sel),
        .d_out     (d_out),
        .out_valid (out_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] payload(input logic [1:0] idx);
        return 32'hA000_0000 + 32'(idx);
    endfunction

    // Outputs seen during this cycle are (v,g,s,t); inputs r,d are sampled at the closing edge.
    task automatic cyc(input logic [3:0] r, input logic d, input bit v,
                       input logic [3:0] g, input logic [1:0] s, input logic t);
        exp_t e;
        req  = r;
        done = d;
        if (v) begin
            e = '{grant: g, sel: s, data: payload(s), tmo: t};
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: got grant=%b sel=%0d, expected no active grant at %0t",
                         grant, sel, $time);
            end else begin
                e = q.pop_front();
                check("grant",   32'(grant),   32'(e.grant));
                check("sel",     32'(sel),     32'(e.sel));
                check("d_out",   d_out,        e.data);
                check("timeout", 32'(timeout), 32'(e.tmo));
            end
        end else begin
            check("idle_grant",   32'(grant),   32'd0);
            check("idle_timeout", 32'(timeout), 32'd0);
        end
    end

    initial begin
        exp_t e;
        rst_n  = 1'b0;
        req    = 4'b0000;
        done   = 1'b0;
        d_in_1 = 32'hA000_0000;
        d_in_2 = 32'hA000_0001;
        d_in_3 = 32'hA000_0002;
        d_in_4 = 32'hA000_0003;
        #22;
        check("rst_grant",     32'(grant),     32'd0);
        check("rst_sel",       32'(sel),       32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_timeout",   32'(timeout),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full rotation with done every 2nd grant cycle: 0,1,2,3,0.
        cyc(4'b1111, 1'b0, 0, 4'b0000, 2'd0, 1'b0);
        cyc(4'b1111, 1'b0, 1, 4'b0001, 2'd0, 1'b0);
        cyc(4'b1111, 1'b1, 1, 4'b0001, 2'd0, 1'b0);
        cyc(4'b1111, 1'b0, 1, 4'b0010, 2'd1, 1'b0);
        cyc(4'b1111, 1'b1, 1, 4'b0010, 2'd1, 1'b0);
        cyc(4'b1111, 1'b0, 1, 4'b0100, 2'd2, 1'b0);
        cyc(4'b1111, 1'b1, 1, 4'b0100, 2'd2, 1'b0);
        cyc(4'b1111, 1'b0, 1, 4'b1000, 2'd3, 1'b0);
        cyc(4'b1111, 1'b1, 1, 4'b1000, 2'd3, 1'b0);
        cyc(4'b1111, 1'b0, 1, 4'b0001, 2'd0, 1'b0);
        cyc(4'b0100, 1'b1, 1, 4'b0001, 2'd0, 1'b0);

        // Lone requester 2 with done every cycle: re-granted with no idle gap.
        for (int i = 0; i < 4; i++) cyc(4'b0100, 1'b1, 1, 4'b0100, 2'd2, 1'b0);

        // Withdrawal with done=0, then a fresh request one cycle to grant.
        cyc(4'b0000, 1'b0, 1, 4'b0100, 2'd2, 1'b0);
        cyc(4'b0000, 1'b0, 0, 4'b0000, 2'd0, 1'b0);
        cyc(4'b0100, 1'b0, 0, 4'b0000, 2'd0, 1'b0);
        cyc(4'b0000, 1'b1, 1, 4'b0100, 2'd2, 1'b0);

        // Timeout after 4 cycles, pulse alongside the handover; then done coincides with the timeout cycle.
        cyc(4'b0011, 1'b0, 0, 4'b0000, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(4'b0011, 1'b0, 1, 4'b0001, 2'd0, 1'b0);
        cyc(4'b0011, 1'b0, 1, 4'b0010, 2'd1, 1'b1);
        cyc(4'b0011, 1'b0, 1, 4'b0010, 2'd1, 1'b0);
        cyc(4'b0011, 1'b0, 1, 4'b0010, 2'd1, 1'b0);
        cyc(4'b0011, 1'b1, 1, 4'b0010, 2'd1, 1'b0);
        cyc(4'b0000, 1'b0, 1, 4'b0001, 2'd0, 1'b0);
        cyc(4'b0100, 1'b0, 0, 4'b0000, 2'd0, 1'b0);

        // Asynchronous reset in the middle of a grant to requester 2.
        req  = 4'b0100;
        done = 1'b0;
        e = '{grant: 4'b0100, sel: 2'd2, data: payload(2'd2), tmo: 1'b0};
        q.push_back(e);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_grant",     32'(grant),     32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_sel",       32'(sel),       32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // After reset requester 0 outranks requester 3; then 3 follows.
        cyc(4'b1001, 1'b0, 0, 4'b0000, 2'd0, 1'b0);
        cyc(4'b1001, 1'b1, 1, 4'b0001, 2'd0, 1'b0);
        cyc(4'b0000, 1'b1, 1, 4'b1000, 2'd3, 1'b0);
        cyc(4'b0000, 1'b0, 0, 4'b0000, 2'd0, 1'b0);
        cyc(4'b0000, 1'b0, 0, 4'b0000, 2'd0, 1'b0);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
